// File: rtl/reporte_uart_ocupacion_pkg.sv
// Shared constants and encodings for the parking-lot occupancy UART reporter.
package reporte_uart_ocupacion_pkg;

  localparam logic [7:0] CHAR_E  = 8'h45;
  localparam logic [7:0] CHAR_S  = 8'h53;
  localparam logic [7:0] CHAR_L  = 8'h4C;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam int unsigned MSG_LEN = 3;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_SEND} seq_state_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  typedef enum logic {EVT_ENTRY = 1'b0, EVT_EXIT = 1'b1} evt_t;

  typedef struct packed {
    evt_t       tipo;
    logic [2:0] cuenta;
  } evento_t;

endpackage

// File: rtl/reporte_uart_ocupacion_uart_tx.sv
// UART 8N1 transmitter; the start bit is driven in the same cycle start is seen,
// so consecutive frames issued right after done are gapless.
module uart_tx_8n1
  import reporte_uart_ocupacion_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned    CW   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(BAUD_DIV - 1);

  tx_state_t     r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_data;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == TX_IDLE) begin
        if (start) begin
          // The start cycle itself is the first cycle of the start bit.
          r_data <= data;
          r_cnt  <= CW'(1);
          r_bit  <= '0;
        end
      end else begin
        r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
        if (r_state == TX_DATA && w_bit_end) r_bit <= r_bit + 3'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    tx     = 1'b1;
    done   = 1'b0;
    case (r_state)
      TX_IDLE: begin
        tx = ~start;
        if (start) w_next = TX_START;
      end
      TX_START: begin
        tx = 1'b0;
        if (w_bit_end) w_next = TX_DATA;
      end
      TX_DATA: begin
        tx = r_data[r_bit];
        if (w_bit_end && r_bit == 3'd7) w_next = TX_STOP;
      end
      TX_STOP: begin
        if (w_bit_end) begin
          done   = 1'b1;
          w_next = TX_IDLE;
        end
      end
      default: w_next = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/reporte_uart_ocupacion.sv
// Occupancy reporter: queues entry/exit events and sends "<E|S><digit>\n" over UART.
// Build option REPORTE_LLENO_EN: an entry reaching count 7 is reported as 'L'.
module reporte_uart_ocupacion
  import reporte_uart_ocupacion_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s,
  input  logic       r,
  input  logic [2:0] leds,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);

  logic       r_cap_vld;
  evt_t       r_cap_tipo;

  evento_t    r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic       w_empty, w_full, w_push, w_pop;
  logic       r_ovf;

  seq_state_t r_seq, w_seq_next;
  evento_t    r_ent;
  logic [1:0] r_idx;
  logic [7:0] w_byte;
  logic       w_start, w_done;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = (r_seq == SEQ_IDLE) && !w_empty;
  // A same-cycle pop frees a slot, so a push into a full queue still lands.
  assign w_push  = r_cap_vld && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_vld  <= 1'b0;
      r_cap_tipo <= EVT_ENTRY;
      r_wp       <= '0;
      r_rp       <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_cap_vld  <= s ^ r;
      r_cap_tipo <= r ? EVT_EXIT : EVT_ENTRY;
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
      if (r_cap_vld && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= '{tipo: r_cap_tipo, cuenta: leds};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= SEQ_IDLE;
      r_ent <= '{tipo: EVT_ENTRY, cuenta: 3'd0};
      r_idx <= '0;
    end else begin
      r_seq <= w_seq_next;
      if (w_pop) begin
        r_ent <= r_mem[r_rp[AW-1:0]];
        r_idx <= '0;
      end else if (r_seq == SEQ_SEND && w_done && r_idx != 2'(MSG_LEN - 1)) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  always_comb begin
    w_seq_next = r_seq;
    w_start    = 1'b0;
    case (r_seq)
      SEQ_IDLE: if (!w_empty) w_seq_next = SEQ_LOAD;
      SEQ_LOAD: begin
        w_start    = 1'b1;
        w_seq_next = SEQ_SEND;
      end
      SEQ_SEND: if (w_done) w_seq_next = (r_idx == 2'(MSG_LEN - 1)) ? SEQ_IDLE : SEQ_LOAD;
      default:  w_seq_next = SEQ_IDLE;
    endcase
  end

  always_comb begin
    w_byte = CHAR_LF;
    case (r_idx)
      2'd0: begin
        w_byte = (r_ent.tipo == EVT_EXIT) ? CHAR_S : CHAR_E;
`ifdef REPORTE_LLENO_EN
        if (r_ent.tipo == EVT_ENTRY && r_ent.cuenta == 3'd7) w_byte = CHAR_L;
`endif
      end
      2'd1:    w_byte = CHAR_0 + {5'd0, r_ent.cuenta};
      default: w_byte = CHAR_LF;
    endcase
  end

  uart_tx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .data  (w_byte),
    .tx    (tx),
    .done  (w_done)
  );

  assign busy     = (r_seq != SEQ_IDLE) || !w_empty;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_reporte_uart_ocupacion.sv
// Scoreboard bench: stimulus pushes expected message bytes, a UART decoder pops and checks.
module tb_reporte_uart_ocupacion;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s = 1'b0;
  logic       r = 1'b0;
  logic [2:0] leds = 3'd0;
  logic       tx, busy, overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  logic [7:0] m_b;
  bit         m_ab;
  int         kind;
  logic [2:0] cval;

  reporte_uart_ocupacion #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (s),
    .r        (r),
    .leds     (leds),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] head_char(input bit salida, input logic [2:0] c);
    if (salida) return 8'h53;
`ifdef REPORTE_LLENO_EN
    if (c == 3'd7) return 8'h4C;
`endif
    return 8'h45;
  endfunction

  // kind: 0 entry, 1 exit, 2 both at once. Returns in the cycle after the pulse.
  task automatic evento(input int k, input logic [2:0] cnt, input bit expect_msg);
    s = (k != 1);
    r = (k != 0);
    tick();
    s = 1'b0;
    r = 1'b0;
    if (k != 2) begin
      leds = cnt;
      if (expect_msg) begin
        exp_q.push_back(head_char(k == 1, cnt));
        exp_q.push_back(8'h30 + 8'(cnt));
        exp_q.push_back(8'h0A);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (3) tick();
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic mwait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) m_ab = 1'b1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        m_ab = 1'b0;
        mwait(DIV / 2);
        if (!m_ab) check("start_bit", tx, 0);
        for (int k = 0; k < 8; k++) begin
          mwait(DIV);
          m_b[k] = tx;
        end
        mwait(DIV);
        if (!m_ab) begin
          check("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got=%0h expected=none at %0t", m_b, $time);
          end else begin
            check("byte", m_b, exp_q.pop_front());
          end
        end else begin
          while (rst) @(negedge clk);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("reset_idle", {29'd0, tx, busy, overflow}, 32'b100);
      tick();
    end

    // Entry 2->3 with cycle-accurate timing checks
    leds = 3'd2;
    evento(0, 3'd3, 1'b1);
    check("busy_n1", busy, 0);
    tick();
    check("busy_n2", busy, 1);
    check("tx_n2", tx, 1);
    tick();
    check("tx_fall_n3", tx, 0);
    repeat (299) tick();
    check("busy_last", busy, 1);
    check("tx_last_stop", tx, 1);
    tick();
    check("busy_fall", busy, 0);

    repeat (5) tick();
    evento(1, 3'd2, 1'b1);
    wait_idle(1000);

    // Simultaneous s and r: nothing queued
    evento(2, 3'd2, 1'b1);
    for (int i = 0; i < 30; i++) begin
      check("both_no_busy", busy, 0);
      tick();
    end

    // Six entries two cycles apart: one in flight, four queued, one dropped
    for (int i = 0; i < 6; i++) begin
      evento(0, 3'(i + 1), i < 5);
      if (i < 5) check("no_ovf_yet", overflow, 0);
      tick();
    end
    tick();
    check("overflow_set", overflow, 1);
    wait_idle(2000);
    check("overflow_sticky", overflow, 1);

    // Randomized events, each after the reporter has gone idle
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(1, 20)) tick();
      kind = int'($urandom_range(0, 2));
      cval = 3'($urandom_range(0, 7));
      evento(kind, cval, 1'b1);
      wait_idle(400);
    end

    evento(0, 3'd7, 1'b1);
    wait_idle(400);
    evento(1, 3'd6, 1'b1);
    wait_idle(400);

    // Reset in the middle of byte 1
    evento(0, 3'd5, 1'b1);
    repeat (152) tick();
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("tx_after_rst", tx, 1);
    check("busy_after_rst", busy, 0);
    check("ovf_cleared", overflow, 0);
    rst = 1'b0;
    for (int i = 0; i < 350; i++) begin
      check("quiet_after_rst", {30'd0, tx, busy}, 32'b10);
      tick();
    end

    repeat (20) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
